// File: rtl/mem_line_arb_pkg.sv
// mem_line_arb_pkg -- shared types and constants for the memory line arbiter.
//   state_t    : transaction FSM states (IDLE -> WAIT -> RESP -> IDLE)
//   req_id_t   : requester identity (I-cache / D-cache)
//   GNT_IC/DC  : bit positions inside the one-hot grant vector
//   LINE_BYTES : bytes per cache line; LINE_W : line width in bits
package mem_line_arb_pkg;

  localparam int LINE_BYTES = 16;
  localparam int LINE_W     = 128;
  localparam int LINE_OFF_W = $clog2(LINE_BYTES);

  localparam int GNT_IC = 0;
  localparam int GNT_DC = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  typedef enum logic {
    REQ_IC = 1'b0,
    REQ_DC = 1'b1
  } req_id_t;

endpackage

// File: rtl/mem_line_arb_grant.sv
// mem_line_arb_grant -- combinational grant selection between I-cache and D-cache.
//   ic_valid   : I-cache request pending
//   dc_valid   : D-cache request pending
//   last_grant : requester granted most recently (ties go to the other one)
//   grant      : one-hot grant, bit GNT_IC / GNT_DC; zero when nobody requests
module mem_line_arb_grant
  import mem_line_arb_pkg::*;
(
  input  logic       ic_valid,
  input  logic       dc_valid,
  input  req_id_t    last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (ic_valid && dc_valid) begin
      if (last_grant == REQ_IC) begin
        grant[GNT_DC] = 1'b1;
      end else begin
        grant[GNT_IC] = 1'b1;
      end
    end else if (dc_valid) begin
      grant[GNT_DC] = 1'b1;
    end else if (ic_valid) begin
      grant[GNT_IC] = 1'b1;
    end
  end

endmodule

// File: rtl/mem_line_arbiter.sv
// mem_line_arbiter -- shares one line RAM between an I-cache and a D-cache,
// one line transaction in flight at a time.
//   Parameters : MEM_LATENCY (edges from accept to response, >= 1), ADDR_W
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   ic_req_*   : I-cache line-read request / ready
//   ic_resp_*  : I-cache response pulse and line data
//   dc_req_*   : D-cache request (we=1 write-back, we=0 refill) / ready
//   dc_resp_*  : D-cache response pulse (read data or write ack) and line data
//   mem_*      : line-RAM interface (combinational read data in mem_rdata)
// Optional feature: define MEM_LINE_ARB_RR_EN for round-robin tie-breaking;
// without it the D-cache always wins a tie.
module mem_line_arbiter
  import mem_line_arb_pkg::*;
#(
  parameter int MEM_LATENCY = 2,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ic_req_valid,
  input  logic [ADDR_W-1:0] ic_req_addr,
  output logic              ic_req_ready,
  output logic              ic_resp_valid,
  output logic [LINE_W-1:0] ic_resp_data,
  input  logic              dc_req_valid,
  input  logic              dc_req_we,
  input  logic [ADDR_W-1:0] dc_req_addr,
  input  logic [LINE_W-1:0] dc_req_wdata,
  output logic              dc_req_ready,
  output logic              dc_resp_valid,
  output logic [LINE_W-1:0] dc_resp_data,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_read_addr,
  output logic [ADDR_W-1:0] mem_write_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata
);

  localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  if (MEM_LATENCY < 1) begin : g_bad_latency
    $error("mem_line_arbiter: MEM_LATENCY must be at least 1");
  end

  state_t              state_reg,  state_next;
  logic [CNT_W-1:0]    count_reg,  count_next;
  logic [ADDR_W-1:0]   addr_reg,   addr_next;
  logic                we_reg,     we_next;
  logic [LINE_W-1:0]   wdata_reg,  wdata_next;
  req_id_t             owner_reg,  owner_next;
  logic [LINE_W-1:0]   rdata_reg,  rdata_next;

  logic [1:0] grant;
  req_id_t    last_grant;
  logic       ic_accept;
  logic       dc_accept;
  logic       mem_done;

  // Line offset bits are dropped by design; keep them visibly consumed.
  logic unused_offset_bits;
  assign unused_offset_bits = ^{ic_req_addr[LINE_OFF_W-1:0], dc_req_addr[LINE_OFF_W-1:0]};

  mem_line_arb_grant u_grant (
    .ic_valid   (ic_req_valid),
    .dc_valid   (dc_req_valid),
    .last_grant (last_grant),
    .grant      (grant)
  );

  // Ready is gated by rst_n so nothing is offered while reset is held.
  assign ic_req_ready = rst_n && (state_reg == ST_IDLE) && grant[GNT_IC];
  assign dc_req_ready = rst_n && (state_reg == ST_IDLE) && grant[GNT_DC];
  assign ic_accept    = ic_req_valid && ic_req_ready;
  assign dc_accept    = dc_req_valid && dc_req_ready;

`ifdef MEM_LINE_ARB_RR_EN
  req_id_t last_grant_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_reg <= REQ_IC;
    end else if (ic_accept || dc_accept) begin
      last_grant_reg <= dc_accept ? REQ_DC : REQ_IC;
    end
  end

  assign last_grant = last_grant_reg;
`else
  // Pretending the I-cache was granted last makes every tie go to the D-cache.
  assign last_grant = REQ_IC;
`endif

  // The RAM operation happens in the final WAIT cycle (counter at zero).
  assign mem_done = (state_reg == ST_WAIT) && (count_reg == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      count_reg <= '0;
      addr_reg  <= '0;
      we_reg    <= 1'b0;
      wdata_reg <= '0;
      owner_reg <= REQ_IC;
      rdata_reg <= '0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      addr_reg  <= addr_next;
      we_reg    <= we_next;
      wdata_reg <= wdata_next;
      owner_reg <= owner_next;
      rdata_reg <= rdata_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    addr_next  = addr_reg;
    we_next    = we_reg;
    wdata_next = wdata_reg;
    owner_next = owner_reg;
    rdata_next = rdata_reg;
    case (state_reg)
      ST_IDLE: begin
        if (dc_accept) begin
          state_next = ST_WAIT;
          count_next = CNT_W'(MEM_LATENCY - 1);
          addr_next  = {dc_req_addr[ADDR_W-1:LINE_OFF_W], LINE_OFF_W'(0)};
          we_next    = dc_req_we;
          wdata_next = dc_req_wdata;
          owner_next = REQ_DC;
        end else if (ic_accept) begin
          state_next = ST_WAIT;
          count_next = CNT_W'(MEM_LATENCY - 1);
          addr_next  = {ic_req_addr[ADDR_W-1:LINE_OFF_W], LINE_OFF_W'(0)};
          we_next    = 1'b0;
          wdata_next = '0;
          owner_next = REQ_IC;
        end
      end
      ST_WAIT: begin
        if (count_reg == '0) begin
          state_next = ST_RESP;
          if (!we_reg) begin
            rdata_next = mem_rdata;
          end
        end else begin
          count_next = count_reg - CNT_W'(1);
        end
      end
      ST_RESP: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign mem_we         = mem_done && we_reg;
  assign mem_read_addr  = addr_reg;
  assign mem_write_addr = addr_reg;
  assign mem_wdata      = wdata_reg;

  assign ic_resp_valid  = (state_reg == ST_RESP) && (owner_reg == REQ_IC);
  assign dc_resp_valid  = (state_reg == ST_RESP) && (owner_reg == REQ_DC);
  assign ic_resp_data   = rdata_reg;
  assign dc_resp_data   = rdata_reg;

endmodule

// File: tb/tb_mem_line_arbiter.sv
// tb_mem_line_arbiter -- self-checking bench for mem_line_arbiter (MEM_LATENCY=3).
// Directed reset / read / write / arbitration / mid-transaction-reset steps,
// then randomized transactions against a transaction-level reference model.
// Honors MEM_LINE_ARB_RR_EN the same way the design does.
module tb_mem_line_arbiter;

  localparam int L = 3;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         ic_req_valid;
  logic [31:0]  ic_req_addr;
  logic         ic_req_ready;
  logic         ic_resp_valid;
  logic [127:0] ic_resp_data;
  logic         dc_req_valid;
  logic         dc_req_we;
  logic [31:0]  dc_req_addr;
  logic [127:0] dc_req_wdata;
  logic         dc_req_ready;
  logic         dc_resp_valid;
  logic [127:0] dc_resp_data;
  logic         mem_we;
  logic [31:0]  mem_read_addr;
  logic [31:0]  mem_write_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;

  // Line RAM behind the arbiter (16 lines, byte addresses 0x00..0xFF).
  logic [127:0] ram     [16];
  // Reference model state.
  logic [127:0] exp_mem [16];
  logic [127:0] exp_last_read;
  bit           model_last_dc;

  int checks = 0;
  int errors = 0;
  int txn_no = 0;

  always #5 clk = ~clk;

  assign mem_rdata = ram[mem_read_addr[7:4]];

  always @(posedge clk) begin
    if (mem_we) ram[mem_write_addr[7:4]] <= mem_wdata;
  end

  mem_line_arbiter #(.MEM_LATENCY(L), .ADDR_W(32)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ic_req_valid   (ic_req_valid),
    .ic_req_addr    (ic_req_addr),
    .ic_req_ready   (ic_req_ready),
    .ic_resp_valid  (ic_resp_valid),
    .ic_resp_data   (ic_resp_data),
    .dc_req_valid   (dc_req_valid),
    .dc_req_we      (dc_req_we),
    .dc_req_addr    (dc_req_addr),
    .dc_req_wdata   (dc_req_wdata),
    .dc_req_ready   (dc_req_ready),
    .dc_resp_valid  (dc_resp_valid),
    .dc_resp_data   (dc_resp_data),
    .mem_we         (mem_we),
    .mem_read_addr  (mem_read_addr),
    .mem_write_addr (mem_write_addr),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ic_ready"},  128'(ic_req_ready),   128'(0));
    chk({tag, "_dc_ready"},  128'(dc_req_ready),   128'(0));
    chk({tag, "_ic_rvalid"}, 128'(ic_resp_valid),  128'(0));
    chk({tag, "_dc_rvalid"}, 128'(dc_resp_valid),  128'(0));
    chk({tag, "_ic_rdata"},  ic_resp_data,         128'(0));
    chk({tag, "_dc_rdata"},  dc_resp_data,         128'(0));
    chk({tag, "_mem_we"},    128'(mem_we),         128'(0));
    chk({tag, "_raddr"},     128'(mem_read_addr),  128'(0));
    chk({tag, "_waddr"},     128'(mem_write_addr), 128'(0));
    chk({tag, "_wdata"},     mem_wdata,            128'(0));
  endtask

  // One complete transaction from the arbiter's IDLE state. The model decides
  // the winner from the tie rule, predicts the response timing (L edges after
  // accept), the single write-enable cycle and the returned line.
  task automatic run_txn(input bit icv, input bit dcv, input bit we,
                         input logic [31:0] ia, input logic [31:0] da,
                         input logic [127:0] wd);
    bit           tie_dc;
    bit           win_dc;
    bit           eff_we;
    logic [31:0]  a;
`ifdef MEM_LINE_ARB_RR_EN
    tie_dc = !model_last_dc;
`else
    tie_dc = 1'b1;
`endif
    win_dc = dcv && (!icv || tie_dc);
    eff_we = win_dc && we;
    a      = win_dc ? {da[31:4], 4'h0} : {ia[31:4], 4'h0};

    @(negedge clk);
    ic_req_valid = icv;  ic_req_addr = ia;
    dc_req_valid = dcv;  dc_req_addr = da;  dc_req_we = we;  dc_req_wdata = wd;
    #1;
    chk("ic_ready", 128'(ic_req_ready), 128'(!win_dc));
    chk("dc_ready", 128'(dc_req_ready), 128'(win_dc));
    @(posedge clk);
    for (int k = 0; k <= L; k++) begin
      @(negedge clk);
      if (k == 0) begin
        chk("ic_ready_busy", 128'(ic_req_ready), 128'(0));
        chk("dc_ready_busy", 128'(dc_req_ready), 128'(0));
        chk("raddr", 128'(mem_read_addr), 128'(a));
        chk("waddr", 128'(mem_write_addr), 128'(a));
        ic_req_valid = 1'b0;
        dc_req_valid = 1'b0;
      end
      chk("mem_we", 128'(mem_we), 128'(eff_we && (k == L - 1)));
      if (eff_we && (k == L - 1)) chk("mem_wdata", mem_wdata, wd);
      chk("ic_rvalid", 128'(ic_resp_valid), 128'(!win_dc && (k == L)));
      chk("dc_rvalid", 128'(dc_resp_valid), 128'(win_dc && (k == L)));
      if (k == L) begin
        if (!eff_we) exp_last_read = exp_mem[a[7:4]];
        chk("ic_rdata", ic_resp_data, exp_last_read);
        chk("dc_rdata", dc_resp_data, exp_last_read);
      end
    end
    if (eff_we) exp_mem[a[7:4]] = wd;
    model_last_dc = win_dc;
    txn_no++;
    $display("txn %0d: ic_v=%0d dc_v=%0d -> %s %s line 0x%02h data=%h",
             txn_no, icv, dcv, win_dc ? "DC" : "IC", eff_we ? "write" : "read",
             a[7:0], eff_we ? wd : exp_last_read);
    @(posedge clk);
  endtask

  initial begin
    logic [127:0] wd;
    int           sel;

    for (int i = 0; i < 16; i++) begin
      ram[i]     = {$urandom, $urandom, $urandom, $urandom};
      exp_mem[i] = ram[i];
    end
    exp_last_read = '0;
    model_last_dc = 1'b0;

    // Reset held with both requesters asking: nothing may be offered.
    rst_n        = 1'b0;
    ic_req_valid = 1'b1;  ic_req_addr = 32'h33;
    dc_req_valid = 1'b1;  dc_req_addr = 32'h47;
    dc_req_we    = 1'b1;  dc_req_wdata = {4{32'hA5A5_5A5A}};
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    ic_req_valid = 1'b0;
    dc_req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // I-cache read with unaligned address 0x13 -> line 0x10.
    run_txn(1'b1, 1'b0, 1'b0, 32'h13, 32'h0, 128'h0);

    // D-cache write-back then refill of the same line.
    run_txn(1'b0, 1'b1, 1'b1, 32'h0, 32'h20, 128'h0123456789ABCDEF_FEDCBA9876543210);
    run_txn(1'b0, 1'b1, 1'b0, 32'h0, 32'h2C, 128'h0);
    chk("wb_readback", dc_resp_data, 128'h0123456789ABCDEF_FEDCBA9876543210);

    // Continuous contention: alternate (round robin) or D-cache only.
    for (int i = 0; i < 4; i++) begin
      run_txn(1'b1, 1'b1, 1'b0, 32'h50 + 32'(i * 16), 32'h90 + 32'(i * 16), 128'h0);
    end

    // Reset during the WAIT phase of a D-cache write discards it.
    wd = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    dc_req_valid = 1'b1;  dc_req_we = 1'b1;  dc_req_addr = 32'h45;  dc_req_wdata = wd;
    @(posedge clk);
    @(negedge clk);
    dc_req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_all_zero("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    model_last_dc = 1'b0;
    exp_last_read = '0;
    for (int i = 0; i < L + 2; i++) begin
      @(negedge clk);
      chk("post_reset_mem_we", 128'(mem_we), 128'(0));
      chk("post_reset_rvalid", 128'({ic_resp_valid, dc_resp_valid}), 128'(0));
    end
    chk("post_reset_ram", ram[4], exp_mem[4]);
    run_txn(1'b1, 1'b0, 1'b0, 32'h47, 32'h0, 128'h0);

    // Randomized traffic against the model.
    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(1, 3);
      wd  = {$urandom, $urandom, $urandom, $urandom};
      run_txn(sel[0], sel[1], 1'($urandom_range(0, 1)),
              32'($urandom_range(0, 255)), 32'($urandom_range(0, 255)), wd);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
